mem_wb_pipe_stage: RTL and testbench

//  MEM->WB pipeline stage register for the pipelined ARM datapath.

---
 rtl/mem_wb_pipe_stage_if.sv | 42 ++++
 rtl/mem_wb_pipe_stage.sv | 122 ++++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_stage_if.sv
// MEM->WB stage bundle: M-side handshake and payload in, W-side handshake and payload out.
interface mem_wb_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              pcsrc_m;
  logic              regwrite_m;
  logic              memtoreg_m;
  logic [DATA_W-1:0] read_data_m;
  logic [DATA_W-1:0] alu_result_m;
  logic [DATA_W-1:0] branch_res_m;
  logic [ADDR_W-1:0] wa3_m;

  logic              out_valid;
  logic              out_ready;
  logic              pcsrc_w;
  logic              regwrite_w;
  logic              memtoreg_w;
  logic [DATA_W-1:0] read_data_w;
  logic [DATA_W-1:0] alu_result_w;
  logic [DATA_W-1:0] branch_res_w;
  logic [ADDR_W-1:0] wa3_w;
  logic [1:0]        level;

  // Environment side: drives the M-stage bundle and W-stage ready
  modport master (
    output in_valid, pcsrc_m, regwrite_m, memtoreg_m,
           read_data_m, alu_result_m, branch_res_m, wa3_m, out_ready,
    input  in_ready, out_valid, pcsrc_w, regwrite_w, memtoreg_w,
           read_data_w, alu_result_w, branch_res_w, wa3_w, level
  );

  // Pipe stage side
  modport slave (
    input  in_valid, pcsrc_m, regwrite_m, memtoreg_m,
           read_data_m, alu_result_m, branch_res_m, wa3_m, out_ready,
    output in_ready, out_valid, pcsrc_w, regwrite_w, memtoreg_w,
           read_data_w, alu_result_w, branch_res_w, wa3_w, level
  );
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake, synchronous flush and optional
// two-entry skid buffer that keeps in_ready off the W-side ready path.
module mem_wb_pipe_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          SKID_EN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  mem_wb_pipe_stage_if.slave bus
);

  typedef struct packed {
    logic              pcsrc;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_res;
    logic [ADDR_W-1:0] wa3;
  } entry_t;

  // State encoding equals the number of held entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   in_ready_c;
  logic   accept;
  logic   drain;

  assign in_entry = '{
    pcsrc:      bus.pcsrc_m,
    regwrite:   bus.regwrite_m,
    memtoreg:   bus.memtoreg_m,
    read_data:  bus.read_data_m,
    alu_result: bus.alu_result_m,
    branch_res: bus.branch_res_m,
    wa3:        bus.wa3_m
  };

  // Without the skid entry the single register frees up in the same cycle it drains
  assign in_ready_c = SKID_EN ? in_ready_q : (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid & in_ready_c;
  assign drain      = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head        <= '0;
      skid        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      head        <= '0;
      skid        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head        <= in_entry;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          // accept without drain only happens with the skid entry present
          if (accept && !drain) begin
            skid       <= in_entry;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            head <= in_entry;
          end else if (drain) begin
            head        <= '0;
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (drain) begin
            head       <= skid;
            skid       <= '0;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          head        <= '0;
          skid        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.pcsrc_w      = head.pcsrc & out_valid_q;
  assign bus.regwrite_w   = head.regwrite & out_valid_q;
  assign bus.memtoreg_w   = head.memtoreg & out_valid_q;
  assign bus.read_data_w  = head.read_data;
  assign bus.alu_result_w = head.alu_result;
  assign bus.branch_res_w = head.branch_res;
  assign bus.wa3_w        = head.wa3;
  assign bus.level        = state;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: skid (lane 0) and single-register (lane 1) variants
// driven by shared stimulus, each checked against a queue-based reference model.
module tb_mem_wb_pipe_stage;

  typedef struct packed {
    logic        pcsrc;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] br;
    logic [3:0]  wa3;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic d_in_valid = 1'b0;
  logic d_out_ready = 1'b0;
  ent_t d_ent = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int ln, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d got=%h exp=%h t=%0t", nm, ln, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit SKID = (g == 0);

    mem_wb_pipe_stage_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    assign bus.in_valid     = d_in_valid;
    assign bus.pcsrc_m      = d_ent.pcsrc;
    assign bus.regwrite_m   = d_ent.regwrite;
    assign bus.memtoreg_m   = d_ent.memtoreg;
    assign bus.read_data_m  = d_ent.rd;
    assign bus.alu_result_m = d_ent.alu;
    assign bus.branch_res_m = d_ent.br;
    assign bus.wa3_m        = d_ent.wa3;
    assign bus.out_ready    = d_out_ready;

    mem_wb_pipe_stage #(.DATA_W(32), .ADDR_W(4), .SKID_EN(SKID)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
    );

    // Reference: FIFO of accepted bundles, capacity 2 (skid) or 1 (single register)
    ent_t q[$];

    function automatic bit model_ready();
      return SKID ? (q.size() < 2) : (q.size() == 0 || d_out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
      bit acc;
      bit drn;
      if (!rst_n) begin
        q.delete();
      end else if (flush) begin
        q.delete();
      end else begin
        acc = d_in_valid && model_ready();
        drn = (q.size() != 0) && d_out_ready;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(d_ent);
      end
    end

    always @(negedge clk) begin : monitor
      ent_t e;
      e = (q.size() != 0) ? q[0] : '0;
      chk("out_valid", g, 32'(bus.out_valid), 32'(q.size() != 0));
      chk("level", g, 32'(bus.level), 32'(q.size()));
      chk("in_ready", g, 32'(bus.in_ready), 32'(model_ready()));
      chk("pcsrc_w", g, 32'(bus.pcsrc_w), 32'(e.pcsrc));
      chk("regwrite_w", g, 32'(bus.regwrite_w), 32'(e.regwrite));
      chk("memtoreg_w", g, 32'(bus.memtoreg_w), 32'(e.memtoreg));
      chk("read_data_w", g, bus.read_data_w, e.rd);
      chk("alu_result_w", g, bus.alu_result_w, e.alu);
      chk("branch_res_w", g, bus.branch_res_w, e.br);
      chk("wa3_w", g, 32'(bus.wa3_w), 32'(e.wa3));
    end
  end

  function automatic ent_t mk(input logic [3:0] wa, input logic [31:0] alu, input bit rw);
    ent_t e;
    e = '0;
    e.wa3 = wa;
    e.alu = alu;
    e.regwrite = rw;
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.pcsrc    = 1'($urandom);
    e.regwrite = 1'($urandom);
    e.memtoreg = 1'($urandom);
    e.rd       = $urandom;
    e.alu      = $urandom;
    e.br       = $urandom;
    e.wa3      = 4'($urandom);
    return e;
  endfunction

  // Apply inputs for one cycle; returns 1 time unit after the edge that sampled them
  task automatic cyc(input bit v, input ent_t e, input bit o, input bit f);
    d_in_valid  = v;
    d_ent       = e;
    d_out_ready = o;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", 0, 32'(lane[0].bus.level), 32'd0);
    chk("reset_in_ready", 0, 32'(lane[0].bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Single bundle, 1-cycle latency
    cyc(1'b1, mk(4'h3, 32'h0000_00AA, 1'b1), 1'b1, 1'b0);
    chk("t1_valid", 0, 32'(lane[0].bus.out_valid), 32'd1);
    chk("t1_wa3", 0, 32'(lane[0].bus.wa3_w), 32'h3);
    chk("t1_alu", 0, lane[0].bus.alu_result_w, 32'hAA);
    chk("t1_regwrite", 0, 32'(lane[0].bus.regwrite_w), 32'd1);
    chk("t1_level", 0, 32'(lane[0].bus.level), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Fill the skid buffer, third push refused, drain in order
    cyc(1'b1, mk(4'h1, 32'h1, 1'b1), 1'b0, 1'b0);
    cyc(1'b1, mk(4'h2, 32'h2, 1'b1), 1'b0, 1'b0);
    chk("t2_level", 0, 32'(lane[0].bus.level), 32'd2);
    chk("t2_in_ready", 0, 32'(lane[0].bus.in_ready), 32'd0);
    cyc(1'b1, mk(4'h3, 32'h3, 1'b1), 1'b0, 1'b0);
    chk("t2_level_hold", 0, 32'(lane[0].bus.level), 32'd2);
    chk("t2_head_hold", 0, lane[0].bus.alu_result_w, 32'h1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_second", 0, lane[0].bus.alu_result_w, 32'h2);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t2_empty", 0, 32'(lane[0].bus.out_valid), 32'd0);

    // Flush with a full buffer and a valid same-cycle input
    cyc(1'b1, mk(4'h7, 32'h70, 1'b1), 1'b0, 1'b0);
    cyc(1'b1, mk(4'h8, 32'h80, 1'b1), 1'b0, 1'b0);
    cyc(1'b1, mk(4'h9, 32'h90, 1'b1), 1'b0, 1'b1);
    chk("t3_level", 0, 32'(lane[0].bus.level), 32'd0);
    chk("t3_valid", 0, 32'(lane[0].bus.out_valid), 32'd0);
    chk("t3_regwrite", 0, 32'(lane[0].bus.regwrite_w), 32'd0);
    chk("t3_in_ready", 0, 32'(lane[0].bus.in_ready), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Stream with out_ready toggling
    for (int i = 0; i < 8; i++)
      cyc(1'b1, mk(4'(i), 32'h10 + 32'(i), 1'b1), (i % 2) == 0, 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

    // Single-register variant: stall holds, then drain and load on one edge
    cyc(1'b1, mk(4'h5, 32'h5, 1'b1), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("t5_in_ready", 1, 32'(lane[1].bus.in_ready), 32'd0);
    chk("t5_hold", 1, lane[1].bus.alu_result_w, 32'h5);
    cyc(1'b1, mk(4'h6, 32'h6, 1'b1), 1'b1, 1'b0);
    chk("t5_swap", 1, lane[1].bus.alu_result_w, 32'h6);
    chk("t5_level", 1, 32'(lane[1].bus.level), 32'd1);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in mid-cycle with both lanes holding data
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    chk("t6_pre_level", 0, 32'(lane[0].bus.level), 32'd2);
    d_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 0, 32'(lane[0].bus.out_valid), 32'd0);
    chk("t6_level", 0, 32'(lane[0].bus.level), 32'd0);
    chk("t6_alu", 0, lane[0].bus.alu_result_w, 32'd0);
    chk("t6_br", 0, lane[0].bus.branch_res_w, 32'd0);
    chk("t6_valid", 1, 32'(lane[1].bus.out_valid), 32'd0);
    chk("t6_rd", 1, lane[1].bus.read_data_w, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic: mostly-ready phase then a back-pressure-heavy phase
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) != 0, rnd(), ($urandom % 3) != 0, ($urandom % 50) == 0);
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 4) != 0, rnd(), ($urandom % 4) == 0, ($urandom % 80) == 0);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
